// File: rtl/mdl_dmaseq_pkg.sv
// Shared state encoding and constants for the DMA bus-ownership sequencer.
package mdl_dmaseq_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARMED = 3'd1;
  localparam logic [2:0] REQ   = 3'd2;
  localparam logic [2:0] GRANT = 3'd3;
  localparam logic [2:0] OWN   = 3'd4;
  localparam logic [2:0] REL   = 3'd5;

  localparam logic [8:0] PAGE_LEN_FULL = 9'd256;
  localparam logic [7:0] TMO_SAT       = 8'hFF;

  typedef enum logic [2:0] {
    StIdle  = IDLE,
    StArmed = ARMED,
    StReq   = REQ,
    StGrant = GRANT,
    StOwn   = OWN,
    StRel   = REL
  } state_e;

  // A page length of zero encodes a full 256-word page.
  function automatic logic [8:0] page_words(input logic [7:0] len);
    return (len == 8'd0) ? PAGE_LEN_FULL : {1'b0, len};
  endfunction

endpackage

// File: rtl/mdl_dmaseq_tmo.sv
// Saturating 8-bit bus-grant timeout counter; expire_o marks the enable on which
// the count of enables spent waiting reaches TMO_CYCLES.
module mdl_dmaseq_tmo
  import mdl_dmaseq_pkg::*;
#(
  parameter logic [7:0] TMO_CYCLES = 8'd200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ce_i,
  input  logic clr_i,
  input  logic run_i,
  output logic expire_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else if (ce_i) begin
      if (clr_i) begin
        cnt_q <= 8'd0;
      end else if (run_i && (cnt_q != TMO_SAT)) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  // The current enable counts as one, so compare against the incremented value.
  assign expire_o = run_i && (({1'b0, cnt_q} + 9'd1) == {1'b0, TMO_CYCLES});

endmodule

// File: rtl/mdl_dmaseq.sv
// DMA bus-ownership sequencer: BR/BG/BGACK handshake per word, page word count.
// Optional grant timeout is built when DMASEQ_TIMEOUT_EN is defined.
module mdl_dmaseq
  import mdl_dmaseq_pkg::*;
#(
  parameter logic [7:0] TMO_CYCLES = 8'd200
) (
  input  logic       i_MCLK,
  input  logic       i_SYS_RST,
  input  logic       i_CLK4M_PCEN_n,
  input  logic       i_XFER_START,
  input  logic [7:0] i_PAGE_LEN,
  input  logic       i_ABORT,
  input  logic       i_BR_START_n,
  input  logic       i_DMA_WORD_END,
  input  logic       i_DMA_END,
  input  logic       i_BG_n,
  input  logic       i_AS_n,
  output logic       o_BR_n,
  output logic       o_BGACK_n,
  output logic       o_DMA_ACT,
  output logic [8:0] o_WORD_CNT,
  output logic       o_BUSY,
  output logic       o_XFER_DONE,
  output logic       o_XFER_ABT,
  output logic       o_BUS_TMO
);

  if (TMO_CYCLES == 8'd0) begin : g_bad_tmo
    $error("TMO_CYCLES must be in 1..255");
  end

  state_e     state_q;
  logic [8:0] cnt_q;
  logic       br_n_q, bgack_n_q, dma_act_q;
  logic       done_q, abt_q, tmo_q;
  logic       abt_pend_q, dma_end_q;
  logic       ce, tmo_expire, word_over;

  assign ce        = ~i_CLK4M_PCEN_n;
  assign word_over = i_DMA_WORD_END || (i_DMA_END && !dma_end_q);

`ifdef DMASEQ_TIMEOUT_EN
  logic tmo_clr, tmo_run;
  assign tmo_clr = (state_q == StArmed) && !i_ABORT && !i_BR_START_n;
  assign tmo_run = (state_q == StReq) || (state_q == StGrant);

  mdl_dmaseq_tmo #(
    .TMO_CYCLES(TMO_CYCLES)
  ) u_tmo (
    .clk_i   (i_MCLK),
    .rst_i   (i_SYS_RST),
    .ce_i    (ce),
    .clr_i   (tmo_clr),
    .run_i   (tmo_run),
    .expire_o(tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  always_ff @(posedge i_MCLK or posedge i_SYS_RST) begin
    if (i_SYS_RST) begin
      state_q    <= StIdle;
      cnt_q      <= 9'd0;
      br_n_q     <= 1'b1;
      bgack_n_q  <= 1'b1;
      dma_act_q  <= 1'b0;
      done_q     <= 1'b0;
      abt_q      <= 1'b0;
      tmo_q      <= 1'b0;
      abt_pend_q <= 1'b0;
      dma_end_q  <= 1'b0;
    end else if (ce) begin
      done_q    <= 1'b0;
      abt_q     <= 1'b0;
      tmo_q     <= 1'b0;
      dma_end_q <= i_DMA_END;
      unique case (state_q)
        StIdle: begin
          abt_pend_q <= 1'b0;
          if (i_XFER_START) begin
            cnt_q   <= page_words(i_PAGE_LEN);
            state_q <= StArmed;
          end
        end
        StArmed: begin
          if (i_ABORT) begin
            abt_q   <= 1'b1;
            state_q <= StIdle;
          end else if (!i_BR_START_n) begin
            br_n_q  <= 1'b0;
            state_q <= StReq;
          end
        end
        // Abort outranks timeout, which outranks grant.
        StReq, StGrant: begin
          if (i_ABORT) begin
            br_n_q  <= 1'b1;
            abt_q   <= 1'b1;
            state_q <= StIdle;
          end else if (tmo_expire) begin
            br_n_q  <= 1'b1;
            tmo_q   <= 1'b1;
            cnt_q   <= 9'd0;
            state_q <= StIdle;
          end else if ((state_q == StReq) && !i_BG_n) begin
            state_q <= StGrant;
          end else if ((state_q == StGrant) && i_AS_n && !i_BG_n) begin
            br_n_q    <= 1'b1;
            bgack_n_q <= 1'b0;
            dma_act_q <= 1'b1;
            state_q   <= StOwn;
          end
        end
        StOwn: begin
          if (i_ABORT) begin
            abt_pend_q <= 1'b1;
          end
          if (word_over) begin
            bgack_n_q <= 1'b1;
            dma_act_q <= 1'b0;
            cnt_q     <= cnt_q - 9'd1;
            state_q   <= StRel;
          end
        end
        StRel: begin
          abt_pend_q <= 1'b0;
          if (cnt_q == 9'd0) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (abt_pend_q) begin
            abt_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            state_q <= StArmed;
          end
        end
        default: begin
          br_n_q    <= 1'b1;
          bgack_n_q <= 1'b1;
          dma_act_q <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  assign o_BR_n      = br_n_q;
  assign o_BGACK_n   = bgack_n_q;
  assign o_DMA_ACT   = dma_act_q;
  assign o_WORD_CNT  = cnt_q;
  assign o_BUSY      = (state_q != StIdle);
  assign o_XFER_DONE = done_q;
  assign o_XFER_ABT  = abt_q;
  assign o_BUS_TMO   = tmo_q;

endmodule

// File: tb/tb_mdl_dmaseq.sv
// Scoreboard bench for mdl_dmaseq: stimulus queues expected completion events,
// a monitor pops them whenever a done/abort/timeout pulse appears.
module tb_mdl_dmaseq;

  localparam int KDone = 0;
  localparam int KAbt  = 1;
  localparam int KTmo  = 2;

  typedef struct {
    int kind;
    int cnt;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pcen_n = 1'b1;
  logic       xfer_start = 1'b0;
  logic [7:0] page_len = 8'd0;
  logic       abort = 1'b0;
  logic       br_start_n = 1'b1;
  logic       word_end = 1'b0;
  logic       dma_end = 1'b0;
  logic       bg_n = 1'b1;
  logic       as_n = 1'b1;

  logic       o_BR_n, o_BGACK_n, o_DMA_ACT, o_BUSY;
  logic       o_XFER_DONE, o_XFER_ABT, o_BUS_TMO;
  logic [8:0] o_WORD_CNT;

  int  total = 0;
  int  bad = 0;
  int  bgack_falls = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  mdl_dmaseq #(
    .TMO_CYCLES(8'd10)
  ) dut (
    .i_MCLK        (clk),
    .i_SYS_RST     (rst),
    .i_CLK4M_PCEN_n(pcen_n),
    .i_XFER_START  (xfer_start),
    .i_PAGE_LEN    (page_len),
    .i_ABORT       (abort),
    .i_BR_START_n  (br_start_n),
    .i_DMA_WORD_END(word_end),
    .i_DMA_END     (dma_end),
    .i_BG_n        (bg_n),
    .i_AS_n        (as_n),
    .o_BR_n        (o_BR_n),
    .o_BGACK_n     (o_BGACK_n),
    .o_DMA_ACT     (o_DMA_ACT),
    .o_WORD_CNT    (o_WORD_CNT),
    .o_BUSY        (o_BUSY),
    .o_XFER_DONE   (o_XFER_DONE),
    .o_XFER_ABT    (o_XFER_ABT),
    .o_BUS_TMO     (o_BUS_TMO)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One enabled MCLK edge followed by one disabled edge.
  task automatic step();
    @(negedge clk);
    pcen_n = 1'b0;
    @(posedge clk);
    #1;
    pcen_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int cnt);
    ev_t e;
    e.kind = kind;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  task automatic start(input logic [7:0] len);
    page_len   = len;
    xfer_start = 1'b1;
    step();
    xfer_start = 1'b0;
  endtask

  // Full word handshake from ARMED; exp_cnt is the count after the word.
  task automatic do_word(input int exp_cnt, input bit by_dma_end);
    br_start_n = 1'b0;
    step();
    chk("req_br", o_BR_n, 0);
    chk("req_bgack", o_BGACK_n, 1);
    br_start_n = 1'b1;
    bg_n = 1'b0;
    step();
    chk("grant_br", o_BR_n, 0);
    chk("grant_bgack", o_BGACK_n, 1);
    step();
    chk("own_bgack", o_BGACK_n, 0);
    chk("own_br", o_BR_n, 1);
    chk("own_act", o_DMA_ACT, 1);
    bg_n = 1'b1;
    if (by_dma_end) dma_end = 1'b1;
    else word_end = 1'b1;
    step();
    chk("rel_bgack", o_BGACK_n, 1);
    chk("rel_act", o_DMA_ACT, 0);
    chk("rel_cnt", o_WORD_CNT, exp_cnt);
    word_end = 1'b0;
    dma_end  = 1'b0;
    step();
    chk("after_busy", o_BUSY, (exp_cnt != 0) ? 1 : 0);
  endtask

  // Monitor: checks every enabled edge, pops the scoreboard on event pulses.
  always begin
    logic prev_bgack_n;
    ev_t  e;
    int   kind, npulse;
    prev_bgack_n = 1'b1;
    forever begin
      @(posedge clk);
      if (!pcen_n && !rst) begin
        #1;
        chk("br_bgack_overlap", (!o_BR_n && !o_BGACK_n) ? 1 : 0, 0);
        if (prev_bgack_n && !o_BGACK_n) bgack_falls++;
        prev_bgack_n = o_BGACK_n;
        npulse = int'(o_XFER_DONE) + int'(o_XFER_ABT) + int'(o_BUS_TMO);
        if (npulse != 0) begin
          kind = o_XFER_DONE ? KDone : (o_XFER_ABT ? KAbt : KTmo);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", kind, $time);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cnt", o_WORD_CNT, e.cnt);
            chk("event_busy", o_BUSY, 0);
            chk("event_single", npulse, 1);
          end
        end
      end else if (rst) begin
        prev_bgack_n = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_br", o_BR_n, 1);
    chk("rst_bgack", o_BGACK_n, 1);
    chk("rst_act", o_DMA_ACT, 0);
    chk("rst_cnt", o_WORD_CNT, 0);
    chk("rst_busy", o_BUSY, 0);
    chk("rst_pulses", int'(o_XFER_DONE) + int'(o_XFER_ABT) + int'(o_BUS_TMO), 0);
    @(negedge clk);
    rst = 1'b0;

    // Normal 3-word page, last word ended by a DMA_END rise.
    start(8'd3);
    chk("p3_cnt", o_WORD_CNT, 3);
    chk("p3_busy", o_BUSY, 1);
    do_word(2, 1'b0);
    do_word(1, 1'b0);
    push(KDone, 0);
    do_word(0, 1'b1);
    chk("p3_bgack_windows", bgack_falls, 3);
    chk("p3_cnt_end", o_WORD_CNT, 0);

    // Full page.
    start(8'd0);
    chk("p256_cnt", o_WORD_CNT, 256);
    for (int i = 255; i >= 1; i--) do_word(i, 1'b0);
    push(KDone, 0);
    do_word(0, 1'b0);
    chk("p256_busy", o_BUSY, 0);

    // Grant while a CPU bus cycle is still running.
    start(8'd1);
    br_start_n = 1'b0;
    step();
    br_start_n = 1'b1;
    bg_n = 1'b0;
    as_n = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("as_hold_bgack", o_BGACK_n, 1);
      chk("as_hold_br", o_BR_n, 0);
    end
    as_n = 1'b1;
    step();
    chk("as_rel_bgack", o_BGACK_n, 0);
    bg_n = 1'b1;
    word_end = 1'b1;
    push(KDone, 0);
    step();
    word_end = 1'b0;
    step();

    // Grant never arrives.
    start(8'd5);
    br_start_n = 1'b0;
    step();
    br_start_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("tmo_wait_br", o_BR_n, 0);
      chk("tmo_wait_pulse", o_BUS_TMO, 0);
    end
`ifdef DMASEQ_TIMEOUT_EN
    push(KTmo, 0);
    step();
    chk("tmo_br", o_BR_n, 1);
    chk("tmo_busy", o_BUSY, 0);
    chk("tmo_cnt", o_WORD_CNT, 0);
`else
    step();
    chk("notmo_br", o_BR_n, 0);
    chk("notmo_busy", o_BUSY, 1);
    abort = 1'b1;
    push(KAbt, 5);
    step();
    abort = 1'b0;
    chk("notmo_abt_br", o_BR_n, 1);
`endif

    // Abort in OWN: word finishes first.
    start(8'd4);
    br_start_n = 1'b0;
    step();
    br_start_n = 1'b1;
    bg_n = 1'b0;
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("aown_bgack", o_BGACK_n, 0);
    chk("aown_act", o_DMA_ACT, 1);
    bg_n = 1'b1;
    word_end = 1'b1;
    step();
    word_end = 1'b0;
    chk("aown_rel_cnt", o_WORD_CNT, 3);
    chk("aown_rel_bgack", o_BGACK_n, 1);
    push(KAbt, 3);
    step();
    chk("aown_cnt_hold", o_WORD_CNT, 3);

    // Abort in REQ together with grant.
    start(8'd2);
    br_start_n = 1'b0;
    step();
    br_start_n = 1'b1;
    abort = 1'b1;
    bg_n = 1'b0;
    push(KAbt, 2);
    step();
    abort = 1'b0;
    bg_n = 1'b1;
    chk("areq_br", o_BR_n, 1);
    chk("areq_bgack", o_BGACK_n, 1);
    chk("areq_busy", o_BUSY, 0);

    // Abort on the timeout enable; a stray start mid-request is ignored.
    start(8'd7);
    br_start_n = 1'b0;
    step();
    br_start_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) begin
        page_len = 8'd9;
        xfer_start = 1'b1;
      end
      step();
      xfer_start = 1'b0;
    end
    chk("atmo_cnt_kept", o_WORD_CNT, 7);
    abort = 1'b1;
    push(KAbt, 7);
    step();
    abort = 1'b0;
    chk("atmo_br", o_BR_n, 1);
    chk("atmo_tmo", o_BUS_TMO, 0);

    // Async reset while owning the bus.
    start(8'd2);
    br_start_n = 1'b0;
    step();
    br_start_n = 1'b1;
    bg_n = 1'b0;
    step();
    step();
    bg_n = 1'b1;
    chk("arst_pre_bgack", o_BGACK_n, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_bgack", o_BGACK_n, 1);
    chk("arst_act", o_DMA_ACT, 0);
    chk("arst_br", o_BR_n, 1);
    chk("arst_busy", o_BUSY, 0);
    chk("arst_cnt", o_WORD_CNT, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    step();

    chk("events_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdl_dmaseq.md
# mdl_dmaseq

DMA bus-ownership sequencer for the bubble controller. It sits between the DMA timing block and the host 68000 bus. It turns each word-request strobe into a full bus-request, grant and acknowledge cycle, and tracks the remaining words of a page transfer. It also reports completion, abort and bus-grant timeout to the command/status logic.

## Interface
Parameters:
- TMO_CYCLES, 8'd200, number of 4 MHz enables to wait for bus grant before timeout (1–255).

Ports:
- i_MCLK  in  1  master clock; all state updates on posedge.
- i_SYS_RST  in  1  reset; asynchronous, active-high.
- i_CLK4M_PCEN_n  in  1  4 MHz clock enable, active-low; every register advances only when low.
- i_XFER_START  in  1  one-enable pulse; arms a page transfer.
- i_PAGE_LEN  in  8  words per page, sampled at start; 0 means 256.
- i_ABORT  in  1  level; cancels the transfer.
- i_BR_START_n  in  1  word request from DMA timing, active-low.
- i_DMA_WORD_END  in  1  word transfer completed.
- i_DMA_END  in  1  DMA timing idle.
- i_BG_n  in  1  68000 bus grant.
- i_AS_n  in  1  68000 address strobe.
- o_BR_n  out  1  bus request to the CPU.
- o_BGACK_n  out  1  bus grant acknowledge.
- o_DMA_ACT  out  1  controller owns the bus; feeds i_DMA_ACT of DMA timing.
- o_WORD_CNT  out  9  words remaining, 0–256.
- o_BUSY  out  1  transfer armed or active.
- o_XFER_DONE  out  1  one-enable pulse when the last word completes.
- o_XFER_ABT  out  1  one-enable pulse when an abort is taken.
- o_BUS_TMO  out  1  one-enable pulse when bus grant times out.

## Operation
States: IDLE, ARMED, REQ, GRANT, OWN, REL.

- IDLE
  - On i_XFER_START: load cnt = (i_PAGE_LEN==0) ? 256 : i_PAGE_LEN, then go to ARMED.
  - i_XFER_START in any other state is ignored.
- ARMED
  - If i_ABORT: pulse o_XFER_ABT and go to IDLE.
  - Else if i_BR_START_n==0: go to REQ.
- REQ
  - o_BR_n=0 and the timeout counter runs.
  - If i_BG_n==0: go to GRANT.
  - If i_ABORT: release BR, pulse o_XFER_ABT, go to IDLE.
- GRANT
  - o_BR_n stays 0.
  - Wait for i_AS_n==1 and i_BG_n==0, then go to OWN.
  - The timeout counter keeps running; abort behaves as in REQ.
- OWN
  - o_BGACK_n=0, o_BR_n=1, o_DMA_ACT=1.
  - On i_DMA_WORD_END, or on i_DMA_END rising while in OWN: go to REL.
  - An abort in OWN is latched (abt_pend) and is not taken until the word ends.
- REL
  - o_BGACK_n=1, o_DMA_ACT=0, cnt decrements by 1.
  - If the new cnt==0: pulse o_XFER_DONE and go to IDLE.
  - Else if abt_pend: pulse o_XFER_ABT and go to IDLE.
  - Else: go to ARMED.
- Timeout: when the counter reaches TMO_CYCLES in REQ or GRANT, pulse o_BUS_TMO, drive o_BR_n=1, go to IDLE, and clear cnt.
- Simultaneous events:
  - Abort and grant in the same enable: abort wins.
  - Abort and timeout in the same enable: abort wins, and o_BUS_TMO does not fire.
- o_WORD_CNT = cnt. It holds its value after abort and reads 0 after done or timeout.
- o_BUSY = (state != IDLE).

## Timing
- Reset values: state=IDLE, o_BR_n=1, o_BGACK_n=1, o_DMA_ACT=0, o_WORD_CNT=0, o_BUSY=0, all pulses=0, counter=0, abt_pend=0.
- Reset asserted mid-transfer drops BR and BGACK immediately, without waiting for an enable.
- Each transition takes one 4 MHz enable. Outputs are registered and change on the enable that enters a state.
- Latencies:
  - i_BR_START_n low in ARMED to o_BR_n low: 1 enable.
  - i_BG_n low (with AS high) to o_BGACK_n low: 2 enables (REQ→GRANT→OWN).
  - i_DMA_WORD_END to o_BGACK_n high: 1 enable.
- o_BR_n and o_BGACK_n are never both low for more than 0 enables: BR deasserts on the same edge that BGACK asserts.
- Pulse outputs last exactly one enable period (one 4 MHz cycle).
- The timeout counter clears on entry to REQ and saturates. Timeout fires on the enable where count==TMO_CYCLES.

## Configuration
- DMASEQ_TIMEOUT_EN
  - Defined: the timeout counter and o_BUS_TMO are present as described above.
  - Undefined: no counter; REQ and GRANT wait indefinitely; o_BUS_TMO is tied to 0.

## Structure
- Package mdl_dmaseq_pkg holds:
  - the state encoding localparams (IDLE=0 … REL=5, 3 bits);
  - PAGE_LEN_FULL=9'd256.
- Sub-module mdl_dmaseq_tmo holds the 8-bit saturating grant-timeout counter, with clear, run and expire ports. It is instantiated only under DMASEQ_TIMEOUT_EN.

## Test plan
- Normal page:
  - Stimulus: PAGE_LEN=3, start, then three BR_START_n/BG_n/WORD_END handshakes.
  - Required response: o_WORD_CNT steps 3→2→1→0, one o_XFER_DONE, three BGACK windows, BR and BGACK never low together.
- Full page: PAGE_LEN=0 → o_WORD_CNT=256 after start; 256 words later o_XFER_DONE fires.
- Grant with a bus cycle in progress:
  - Stimulus: BG_n=0 while AS_n=0 for 5 enables.
  - Required response: BGACK stays high until 1 enable after AS_n rises.
- Timeout:
  - Stimulus: TMO_CYCLES=10, BG_n held high.
  - Required response: o_BUS_TMO on the 10th enable in REQ, o_BR_n=1, state IDLE, o_WORD_CNT=0.
- Abort:
  - Abort in OWN: current word completes, cnt decrements, then o_XFER_ABT fires.
  - Abort in REQ: BR releases the next enable.
  - Abort coinciding with timeout: o_XFER_ABT only.
- Async reset in OWN: o_BGACK_n=1 and o_DMA_ACT=0 within the same MCLK cycle, with no enable required.
